uart_tx_fifo: RTL and testbench

- Consumer end of the CPU's byte-output interface (`tx_Data` / `tx_DataValid`).
- Buffers single-cycle byte strobes from the core in a small FIFO.
- Serializes each byte onto the UART line as 8N1, LSB first.
- Sits between the CPU top and the board TX pin. The core has no backpressure, so buffering and overflow reporting live here.

---
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte-strobe FIFO feeding an 8N1 UART transmitter (LSB first).
// The CPU has no backpressure, so strobes that find the FIFO full are
// dropped and flagged through a sticky overflow bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    i_Data,
  input  logic                          i_DataValid,
  output logic                          o_Tx,
  output logic                          o_Busy,
  output logic                          o_Full,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic            pop, push, bit_end;

  assign bit_end = (baud == BAUD_MAX);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push    = i_DataValid && ((count != DEPTH_C) || pop);
  assign o_Count = count;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Frame sequencing: next state, baud/bit counters, line level and pops.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = o_Tx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        baud_n = bit_end ? '0 : baud + BW'(1);
        if (bit_end) begin
          tx_n      = shift[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        baud_n = bit_end ? '0 : baud + BW'(1);
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n      = shift[1];
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        baud_n = bit_end ? '0 : baud + BW'(1);
        tx_n   = 1'b1;
        // Chain straight into the next start bit when more data waits.
        if (bit_end) begin
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_Tx    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      o_Tx    <= tx_n;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Full     <= 1'b0;
      o_Busy     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_n;
      o_Full <= (count_n == DEPTH_C);
      o_Busy <= (state_n != IDLE) || (count_n != '0);
      if (i_DataValid && !push) o_Overflow <= 1'b1;
    end
  end

  // FIFO storage; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= i_Data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model checked every cycle,
// a table of hand-derived vectors and directed multi-cycle sequences.
module tb_uart_tx_fifo;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int FL = 10 * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic       tx, busy, full, ovf;
  logic [2:0] cnt;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .i_Data(data), .i_DataValid(valid),
    .o_Tx(tx), .o_Busy(busy), .o_Full(full), .o_Overflow(ovf), .o_Count(cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of waiting bytes plus the position inside the
  // current frame (0..FL-1); the line level is derived from that position.
  logic [7:0] q[$];
  bit         m_act;
  int         m_pos;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic logic m_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_pos / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx",    32'(tx),   32'(m_tx()));
    chk("busy",  32'(busy), 32'(m_act || q.size() != 0));
    chk("count", 32'(cnt),  32'(q.size()));
    chk("full",  32'(full), 32'(q.size() == D));
    chk("ovf",   32'(ovf),  32'(m_ovf));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bit do_pop, do_push;
    valid   = v;
    data    = d;
    do_pop  = (q.size() > 0) && (!m_act || m_pos == FL - 1);
    do_push = v && (q.size() < D || do_pop);
    @(posedge clk);
    if (v && !do_push) m_ovf = 1'b1;
    if (do_pop) begin
      m_cur = q.pop_front();
      m_act = 1'b1;
      m_pos = 0;
    end else if (m_act) begin
      m_pos++;
      if (m_pos == FL) m_act = 1'b0;
    end
    if (do_push) q.push_back(d);
    #1;
    check_all();
  endtask

  // Strobe held high during reset checks that reset dominates.
  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b1;
    data  = 8'hAA;
    @(posedge clk);
    q.delete();
    m_act = 1'b0;
    m_pos = 0;
    m_ovf = 1'b0;
    #1;
    reset = 1'b0;
    valid = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e_tx;
    logic       e_busy;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n;
    reset = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    m_act = 1'b0;
    m_pos = 0;
    m_ovf = 1'b0;
    m_cur = 8'h00;

    // Fill and overflow from idle: 0x01 leaves on the second edge,
    // 0x05 fills the FIFO, 0x06 is dropped.
    vt[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
    vt[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    vt[5] = '{1'b1, 8'h06, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1};

    @(posedge clk);
    do_reset();
    chk("reset_tx",   32'(tx),   32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnt",  32'(cnt),  32'd0);

    for (int i = 0; i < 7; i++) begin
      step(vt[i].v, vt[i].d);
      chk("vec_tx",   32'(tx),   32'(vt[i].e_tx));
      chk("vec_busy", 32'(busy), 32'(vt[i].e_busy));
      chk("vec_cnt",  32'(cnt),  32'(vt[i].e_cnt));
      chk("vec_full", 32'(full), 32'(vt[i].e_full));
      chk("vec_ovf",  32'(ovf),  32'(vt[i].e_ovf));
    end
    // Let 0x01..0x05 drain onto the line under the model's eye.
    for (int i = 0; i < 5 * FL + 5; i++) step(1'b0, 8'h00);
    chk("fill_drained_busy", 32'(busy), 32'd0);

    // Single byte 0x55: start low from E+1, busy falls at E+41.
    do_reset();
    step(1'b1, 8'h55);
    for (int i = 1; i <= 41; i++) begin
      step(1'b0, 8'h00);
      if (i == 1)  chk("single_start_first", 32'(tx), 32'd0);
      if (i == 4)  chk("single_start_last",  32'(tx), 32'd0);
      if (i == 5)  chk("single_bit0",        32'(tx), 32'd1);
      if (i == 9)  chk("single_bit1",        32'(tx), 32'd0);
      if (i == 40) chk("single_busy_hold",   32'(busy), 32'd1);
      if (i == 41) chk("single_busy_fall",   32'(busy), 32'd0);
    end

    // Back-to-back frames: second start bit exactly 40 cycles after the first.
    do_reset();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    chk("b2b_first_start", 32'(tx), 32'd0);
    for (int i = 2; i <= 81; i++) begin
      step(1'b0, 8'h00);
      if (i == 40) chk("b2b_stop",         32'(tx),   32'd1);
      if (i == 41) chk("b2b_second_start", 32'(tx),   32'd0);
      if (i == 80) chk("b2b_busy_hold",    32'(busy), 32'd1);
      if (i == 81) chk("b2b_busy_fall",    32'(busy), 32'd0);
    end

    // Push into a full FIFO on the cycle the last stop bit pops the head.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i * 17));
    chk("sf_full_cnt", 32'(cnt), 32'd4);
    n = 0;
    while (!(m_act && m_pos == FL - 1) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("sf_wait_bound", 32'(n < 200), 32'd1);
    step(1'b1, 8'h66);
    chk("sf_cnt", 32'(cnt), 32'd4);
    chk("sf_ovf", 32'(ovf), 32'd0);
    chk("sf_tx",  32'(tx),  32'd0);
    for (int i = 0; i < 5 * FL + 5; i++) step(1'b0, 8'h00);
    chk("sf_drained", 32'(busy), 32'd0);

    // Reset in the middle of bit 3 of 0xFF with two bytes queued.
    do_reset();
    step(1'b1, 8'hFF);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    n = 0;
    while (!(m_act && m_pos == 4 * C + 1) && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("rst_wait_bound", 32'(n < 200), 32'd1);
    chk("rst_pre_tx",  32'(tx),  32'd1);
    chk("rst_pre_cnt", 32'(cnt), 32'd2);
    do_reset();
    chk("rst_tx",   32'(tx),   32'd1);
    chk("rst_cnt",  32'(cnt),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00);
      if (tx !== 1'b1) n++;
    end
    chk("rst_no_resume", 32'(n), 32'd0);

    // Ten single strobes one frame apart walk the pointers round twice.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'($urandom));
      for (int j = 0; j < FL - 1; j++) step(1'b0, 8'h00);
    end
    for (int i = 0; i < FL + 2; i++) step(1'b0, 8'h00);
    chk("wrap_idle", 32'(busy), 32'd0);

    // Random bursts fast enough to fill the FIFO and trigger overflow.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else step(($urandom_range(0, 15) == 0), 8'($urandom));
    end
    for (int i = 0; i < 5 * FL + 5; i++) step(1'b0, 8'h00);
    chk("rand_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
